// File: rtl/router_clk_gate_ctrl.sv
// Clock-gate controller for one mesh router: gates the router clock after a
// programmable run of quiet cycles and wakes it combinationally on demand.
module router_clk_gate_ctrl #(
  parameter int IDLE_CYCLES = 4,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [4:0]           si_vec,
  input  logic [4:0]           so_vec,
  input  logic [4:0]           occ_vec,
  input  logic                 gate_en,
  input  logic                 force_on,
  input  logic                 clear_stats,
  output logic                 icg_en,
  output logic                 gated,
  output logic [CNT_WIDTH-1:0] gated_cycles,
  output logic [CNT_WIDTH-1:0] wake_count
);

  localparam int EFF_IDLE = (IDLE_CYCLES < 1) ? 1 : IDLE_CYCLES;
  localparam int IW       = $clog2(EFF_IDLE + 1);
  localparam logic [IW-1:0] TERM_CNT = IW'(EFF_IDLE - 1);

  typedef enum logic [1:0] {
    ACTIVE    = 2'd0,
    IDLE_WAIT = 2'd1,
    GATED     = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] idle_cnt, idle_cnt_nxt;
  logic          quiet, wake;
  logic          gate_inc, wake_inc;

  assign quiet = ~|si_vec & ~|so_vec & ~|occ_vec & gate_en & ~force_on;
  assign wake  = |si_vec | |so_vec | force_on | ~gate_en;

  // Wake opens the latch in the same cycle so the first gated edge sees the request.
  assign icg_en = reset | (state != GATED) | wake;

  always_comb begin
    // NOTE: every signal driven here gets a default first so no latch is inferred.
    state_nxt    = state;
    idle_cnt_nxt = idle_cnt;
    gate_inc     = 1'b0;
    wake_inc     = 1'b0;
    case (state)
      ACTIVE: begin
        if (quiet) begin
          idle_cnt_nxt = IW'(1);
          state_nxt    = (EFF_IDLE == 1) ? GATED : IDLE_WAIT;
        end
      end
      IDLE_WAIT: begin
        if (!quiet) begin
          state_nxt    = ACTIVE;
          idle_cnt_nxt = '0;
        end else if (idle_cnt == TERM_CNT) begin
          state_nxt = GATED;
        end else begin
          idle_cnt_nxt = idle_cnt + IW'(1);
        end
      end
      GATED: begin
        // occ_vec is ignored here: the router is frozen and cannot drain.
        if (wake) begin
          state_nxt    = ACTIVE;
          idle_cnt_nxt = '0;
          wake_inc     = 1'b1;
        end else begin
          gate_inc = 1'b1;
        end
      end
      default: begin
        state_nxt    = ACTIVE;
        idle_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (reset) begin
      state        <= ACTIVE;
      idle_cnt     <= '0;
      gated        <= 1'b0;
      gated_cycles <= '0;
      wake_count   <= '0;
    end else begin
      state    <= state_nxt;
      idle_cnt <= idle_cnt_nxt;
      gated    <= (state_nxt == GATED);
      // Clear wins over a same-cycle increment; counters stick at all-ones.
      if (clear_stats) begin
        gated_cycles <= '0;
        wake_count   <= '0;
      end else begin
        if (gate_inc && !(&gated_cycles)) gated_cycles <= gated_cycles + CNT_WIDTH'(1);
        if (wake_inc && !(&wake_count))   wake_count   <= wake_count + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_router_clk_gate_ctrl.sv
// Randomized and directed bench for router_clk_gate_ctrl, checking two instances
// (IDLE_CYCLES=4/16-bit counters and IDLE_CYCLES=0/4-bit counters) against a quiet-run model.
module tb_router_clk_gate_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  si_vec, so_vec, occ_vec;
  logic        gate_en, force_on, clear_stats;

  logic        icg_en0, gated0, icg_en1, gated1;
  logic [15:0] gated_cycles0, wake_count0;
  logic [3:0]  gated_cycles1, wake_count1;

  int n_cmp = 0;
  int n_err = 0;

  // Model: per instance, a gated flag and the length of the current quiet run.
  bit m_gated[2];
  int m_run[2];
  int m_gc[2];
  int m_wc[2];
  int m_n[2]   = '{4, 1};
  int m_max[2] = '{65535, 15};

  always #5 clk = ~clk;

  router_clk_gate_ctrl #(.IDLE_CYCLES(4), .CNT_WIDTH(16)) dut0 (
    .clk(clk), .reset(reset), .si_vec(si_vec), .so_vec(so_vec), .occ_vec(occ_vec),
    .gate_en(gate_en), .force_on(force_on), .clear_stats(clear_stats),
    .icg_en(icg_en0), .gated(gated0), .gated_cycles(gated_cycles0), .wake_count(wake_count0)
  );

  router_clk_gate_ctrl #(.IDLE_CYCLES(0), .CNT_WIDTH(4)) dut1 (
    .clk(clk), .reset(reset), .si_vec(si_vec), .so_vec(so_vec), .occ_vec(occ_vec),
    .gate_en(gate_en), .force_on(force_on), .clear_stats(clear_stats),
    .icg_en(icg_en1), .gated(gated1), .gated_cycles(gated_cycles1), .wake_count(wake_count1)
  );

  function automatic bit quiet_now();
    return (si_vec == 5'd0) && (so_vec == 5'd0) && (occ_vec == 5'd0) && gate_en && !force_on;
  endfunction

  function automatic bit wake_now();
    return (si_vec != 5'd0) || (so_vec != 5'd0) || force_on || !gate_en;
  endfunction

  function automatic logic exp_icg(int k);
    return reset || !m_gated[k] || wake_now();
  endfunction

  function automatic logic get_icg(int k);
    return (k == 0) ? icg_en0 : icg_en1;
  endfunction

  function automatic logic get_gated(int k);
    return (k == 0) ? gated0 : gated1;
  endfunction

  function automatic logic [31:0] get_gc(int k);
    return (k == 0) ? {16'd0, gated_cycles0} : {28'd0, gated_cycles1};
  endfunction

  function automatic logic [31:0] get_wc(int k);
    return (k == 0) ? {16'd0, wake_count0} : {28'd0, wake_count1};
  endfunction

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_gated[k] = 1'b0; m_run[k] = 0; m_gc[k] = 0; m_wc[k] = 0;
      end else begin
        if (m_gated[k]) begin
          if (wake_now()) begin
            m_gated[k] = 1'b0;
            m_run[k]   = 0;
            if (m_wc[k] < m_max[k]) m_wc[k]++;
          end else if (m_gc[k] < m_max[k]) begin
            m_gc[k]++;
          end
        end else if (quiet_now()) begin
          m_run[k]++;
          if (m_run[k] >= m_n[k]) m_gated[k] = 1'b1;
        end else begin
          m_run[k] = 0;
        end
        if (clear_stats) begin
          m_gc[k] = 0; m_wc[k] = 0;
        end
      end
    end
  endtask

  // One clock: model and DUT both consume the inputs present at the edge.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    si_vec = '0; so_vec = '0; occ_vec = '0;
    gate_en = 1'b1; force_on = 1'b0; clear_stats = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    #1;
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (get_icg(k) !== 1'b1) begin
        n_err++; $display("FAIL reset_icg[%0d]: got %b expected 1", k, get_icg(k));
      end
    end
    cycle(); cycle();
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (get_gated(k) !== 1'b0 || get_gc(k) !== 32'd0 || get_wc(k) !== 32'd0 || get_icg(k) !== 1'b1) begin
        n_err++;
        $display("FAIL reset_state[%0d]: got gated=%b gc=%0h wc=%0h icg=%b expected 0/0/0/1",
                 k, get_gated(k), get_gc(k), get_wc(k), get_icg(k));
      end
    end
    reset = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      n_cmp++;
      if (icg_en0 !== logic'(i <= 4)) begin
        n_err++; $display("FAIL gate_latency icg cycle %0d: got %b expected %b", i, icg_en0, i <= 4);
      end
      n_cmp++;
      if (gated0 !== logic'(i >= 5)) begin
        n_err++; $display("FAIL gate_latency gated cycle %0d: got %b expected %b", i, gated0, i >= 5);
      end
      n_cmp++;
      if (icg_en1 !== exp_icg(1)) begin
        n_err++; $display("FAIL gate_latency_n1 icg cycle %0d: got %b expected %b", i, icg_en1, exp_icg(1));
      end
      cycle();
    end
  endtask

  task automatic test_wake();
    si_vec = 5'b00001;
    #1;
    n_cmp++;
    if (icg_en0 !== 1'b1 || icg_en1 !== 1'b1) begin
      n_err++; $display("FAIL wake_same_cycle: got %b/%b expected 1/1", icg_en0, icg_en1);
    end
    cycle();
    n_cmp++;
    if (wake_count0 !== 16'd1 || gated0 !== 1'b0) begin
      n_err++; $display("FAIL wake_count: got wc=%0d gated=%b expected 1/0", wake_count0, gated0);
    end
    cycle();
    si_vec = '0;
    for (int i = 1; i <= 6; i++) begin
      n_cmp++;
      if (icg_en0 !== logic'(i <= 4)) begin
        n_err++; $display("FAIL regate cycle %0d: got %b expected %b", i, icg_en0, i <= 4);
      end
      cycle();
    end
    n_cmp++;
    if (wake_count0 !== 16'd1 || wake_count1 !== 4'(m_wc[1])) begin
      n_err++; $display("FAIL wake_count_hold: got %0d/%0d expected 1/%0d", wake_count0, wake_count1, m_wc[1]);
    end
  endtask

  task automatic test_so_toggle();
    clear_stats = 1'b1;
    cycle();
    clear_stats = 1'b0;
    for (int i = 0; i < 30; i++) begin
      so_vec = (i % 3 == 0) ? 5'b00100 : 5'b00000;
      #1;
      n_cmp++;
      if (icg_en0 !== 1'b1) begin
        n_err++; $display("FAIL so_toggle icg %0d: got %b expected 1", i, icg_en0);
      end
      cycle();
      n_cmp++;
      if (gated0 !== 1'b0) begin
        n_err++; $display("FAIL so_toggle gated %0d: got %b expected 0", i, gated0);
      end
    end
    so_vec = '0;
    n_cmp++;
    if (gated_cycles0 !== 16'd0 || gated_cycles1 !== 4'(m_gc[1])) begin
      n_err++; $display("FAIL so_toggle gc: got %0d/%0d expected 0/%0d", gated_cycles0, gated_cycles1, m_gc[1]);
    end
  endtask

  task automatic test_gate_en_low();
    gate_en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      n_cmp++;
      if (icg_en0 !== 1'b1 || icg_en1 !== 1'b1) begin
        n_err++; $display("FAIL gate_en_low icg %0d: got %b/%b expected 1/1", i, icg_en0, icg_en1);
      end
      cycle();
    end
    gate_en = 1'b1;
    cycle();
    n_cmp++;
    if (gated1 !== 1'b1 || gated0 !== 1'b0) begin
      n_err++; $display("FAIL gate_en_restore: got gated=%b/%b expected 0/1", gated0, gated1);
    end
  endtask

  task automatic test_reset_while_gated();
    idle_inputs();
    repeat (6) cycle();
    n_cmp++;
    if (gated0 !== 1'b1 || icg_en0 !== 1'b0) begin
      n_err++; $display("FAIL pre_reset_gated: got gated=%b icg=%b expected 1/0", gated0, icg_en0);
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if (icg_en0 !== 1'b1 || icg_en1 !== 1'b1) begin
      n_err++; $display("FAIL reset_gated_icg: got %b/%b expected 1/1", icg_en0, icg_en1);
    end
    cycle();
    reset = 1'b0;
    #1;
    n_cmp++;
    if (gated0 !== 1'b0 || icg_en0 !== 1'b1 || gated_cycles0 !== 16'd0 || wake_count0 !== 16'd0) begin
      n_err++;
      $display("FAIL reset_gated_after: got gated=%b icg=%b gc=%0d wc=%0d expected 0/1/0/0",
               gated0, icg_en0, gated_cycles0, wake_count0);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      si_vec      = ($urandom_range(0, 5) == 0) ? 5'($urandom) : 5'd0;
      so_vec      = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'd0;
      occ_vec     = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'd0;
      gate_en     = ($urandom_range(0, 15) != 0);
      force_on    = ($urandom_range(0, 19) == 0);
      clear_stats = ($urandom_range(0, 49) == 0);
      reset       = ($urandom_range(0, 199) == 0);
      #1;
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (get_icg(k) !== exp_icg(k)) begin
          n_err++; $display("FAIL rand_icg[%0d] @%0d: got %b expected %b", k, i, get_icg(k), exp_icg(k));
        end
      end
      cycle();
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (get_gated(k) !== logic'(m_gated[k])) begin
          n_err++; $display("FAIL rand_gated[%0d] @%0d: got %b expected %b", k, i, get_gated(k), m_gated[k]);
        end
        n_cmp++;
        if (get_gc(k) !== 32'(m_gc[k])) begin
          n_err++; $display("FAIL rand_gc[%0d] @%0d: got %0d expected %0d", k, i, get_gc(k), m_gc[k]);
        end
        n_cmp++;
        if (get_wc(k) !== 32'(m_wc[k])) begin
          n_err++; $display("FAIL rand_wc[%0d] @%0d: got %0d expected %0d", k, i, get_wc(k), m_wc[k]);
        end
      end
    end
    reset = 1'b0;
    idle_inputs();
  endtask

  task automatic test_saturation();
    idle_inputs();
    clear_stats = 1'b1;
    cycle();
    clear_stats = 1'b0;
    repeat (6) cycle();
    repeat (70000) cycle();
    n_cmp++;
    if (gated_cycles0 !== 16'hFFFF || gated_cycles1 !== 4'hF) begin
      n_err++; $display("FAIL saturate: got %0h/%0h expected ffff/f", gated_cycles0, gated_cycles1);
    end
    clear_stats = 1'b1;
    cycle();
    clear_stats = 1'b0;
    n_cmp++;
    if (gated_cycles0 !== 16'd0 || gated_cycles1 !== 4'd0) begin
      n_err++; $display("FAIL clear_priority: got %0h/%0h expected 0/0", gated_cycles0, gated_cycles1);
    end
    cycle();
    n_cmp++;
    if (gated_cycles0 !== 16'd1 || gated_cycles1 !== 4'd1) begin
      n_err++; $display("FAIL count_after_clear: got %0d/%0d expected 1/1", gated_cycles0, gated_cycles1);
    end
  endtask

  initial begin
    test_reset();
    test_wake();
    test_so_toggle();
    test_gate_en_low();
    test_reset_while_gated();
    test_random();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
